// File: rtl/mr_car_counter.sv
`default_nettype none
// ============================================================================
// Module   : mr_car_counter
// Brief    : Debounced arrival/departure loop counter feeding MR_cars.
// Revision : 1.0 - initial release
// ============================================================================
module mr_car_counter #(
    parameter int WIDTH    = 8,
    parameter int DEBOUNCE = 3,
    parameter int MAX_CARS = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             arrive_det,
    input  logic             depart_det,
    input  logic             clr,
    output logic [WIDTH-1:0] MR_cars,
    output logic             arrive_evt,
    output logic             depart_evt,
    output logic             ovf,
    output logic             udf
);

    localparam logic [3:0]       C_DEB_LAST = 4'(DEBOUNCE - 1);
    localparam logic [WIDTH-1:0] C_MAX      = WIDTH'(MAX_CARS);

    // Channel index 0 is arrival, 1 is departure.
    logic [1:0]      s1_q, s1_d;
    logic [1:0]      s2_q, s2_d;
    logic [1:0]      deb_q, deb_d;
    logic [1:0]      deb_prev_q, deb_prev_d;
    logic [1:0][3:0] cnt_q, cnt_d;
    logic [1:0]      evt_q, evt_d;
    logic [WIDTH-1:0] cars_q, cars_d;
    logic            ovf_q, ovf_d;
    logic            udf_q, udf_d;

    always_comb begin
        s1_d       = {depart_det, arrive_det};
        s2_d       = s1_q;
        deb_d      = deb_q;
        cnt_d      = cnt_q;
        deb_prev_d = deb_q;
        for (int i = 0; i < 2; i++) begin
            if (s2_q[i] == deb_q[i]) begin
                cnt_d[i] = 4'd0;
            end else if (cnt_q[i] == C_DEB_LAST) begin
                deb_d[i] = s2_q[i];
                cnt_d[i] = 4'd0;
            end else begin
                cnt_d[i] = cnt_q[i] + 4'd1;
            end
        end
        // Rise of the debounced level, seen one edge after deb itself moves.
        evt_d = deb_q & ~deb_prev_q;
    end

    always_comb begin
        cars_d = cars_q;
        ovf_d  = ovf_q;
        udf_d  = udf_q;
        if (clr) begin
            cars_d = '0;
            ovf_d  = 1'b0;
            udf_d  = 1'b0;
        end else if (evt_d[0] && !evt_d[1]) begin
            if (cars_q < C_MAX) begin
                cars_d = cars_q + WIDTH'(1);
            end else begin
                ovf_d = 1'b1;
            end
        end else if (evt_d[1] && !evt_d[0]) begin
            if (cars_q != '0) begin
                cars_d = cars_q - WIDTH'(1);
            end else begin
                udf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_q       <= '0;
            s2_q       <= '0;
            deb_q      <= '0;
            deb_prev_q <= '0;
            cnt_q      <= '0;
            evt_q      <= '0;
            cars_q     <= '0;
            ovf_q      <= 1'b0;
            udf_q      <= 1'b0;
        end else begin
            s1_q       <= s1_d;
            s2_q       <= s2_d;
            deb_q      <= deb_d;
            deb_prev_q <= deb_prev_d;
            cnt_q      <= cnt_d;
            evt_q      <= evt_d;
            cars_q     <= cars_d;
            ovf_q      <= ovf_d;
            udf_q      <= udf_d;
        end
    end

    assign MR_cars    = cars_q;
    assign arrive_evt = evt_q[0];
    assign depart_evt = evt_q[1];
    assign ovf        = ovf_q;
    assign udf        = udf_q;

endmodule
`default_nettype wire

// File: tb/tb_mr_car_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mr_car_counter
// Brief    : Directed vector bench for mr_car_counter (default and MAX_CARS=5).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mr_car_counter;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       arrive_det = 1'b0, depart_det = 1'b0, clr = 1'b0;
    logic       a5 = 1'b0, d5 = 1'b0, clr5 = 1'b0;
    logic [7:0] cars, cars5;
    logic       aevt, devt, ovf, udf;
    logic       aevt5, devt5, ovf5, udf5;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mr_car_counter #(.WIDTH(8), .DEBOUNCE(3), .MAX_CARS(255)) dut (
        .clk(clk), .rst(rst), .arrive_det(arrive_det), .depart_det(depart_det),
        .clr(clr), .MR_cars(cars), .arrive_evt(aevt), .depart_evt(devt),
        .ovf(ovf), .udf(udf)
    );

    mr_car_counter #(.WIDTH(8), .DEBOUNCE(3), .MAX_CARS(5)) dut5 (
        .clk(clk), .rst(rst), .arrive_det(a5), .depart_det(d5),
        .clr(clr5), .MR_cars(cars5), .arrive_evt(aevt5), .depart_evt(devt5),
        .ovf(ovf5), .udf(udf5)
    );

    typedef struct {
        bit sel;      // 0 = default instance, 1 = MAX_CARS=5 instance
        int a_hi;     // arrival cycles high per 12-cycle window
        int d_hi;     // departure cycles high per window
        int rep;      // number of windows
        int cars;     // expected count afterwards
        int aevt;     // expected arrival pulses over all windows
        int devt;     // expected departure pulses over all windows
        bit ovf;
        bit udf;
    } vec_t;

    vec_t tbl[8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic run_windows(input bit sel, input int a_hi, input int d_hi,
                               input int rep, output int ae, output int de);
        ae = 0;
        de = 0;
        for (int w = 0; w < rep; w++) begin
            for (int k = 0; k < 12; k++) begin
                if (sel) begin
                    a5 = (k < a_hi);
                    d5 = (k < d_hi);
                end else begin
                    arrive_det = (k < a_hi);
                    depart_det = (k < d_hi);
                end
                tick();
                ae += int'(sel ? aevt5 : aevt);
                de += int'(sel ? devt5 : devt);
            end
        end
        a5 = 1'b0; d5 = 1'b0;
        arrive_det = 1'b0; depart_det = 1'b0;
    endtask

    initial begin
        int ae, de;

        tbl[0] = '{0, 6, 0,  9, 10, 9, 0, 0, 0};
        tbl[1] = '{0, 2, 0, 12, 10, 0, 0, 0, 0};
        tbl[2] = '{0, 0, 6,  4,  6, 0, 4, 0, 0};
        tbl[3] = '{0, 6, 6,  1,  6, 1, 1, 0, 0};
        tbl[4] = '{0, 0, 6,  7,  0, 0, 7, 0, 1};
        tbl[5] = '{0, 0, 2,  3,  0, 0, 0, 0, 1};
        tbl[6] = '{0, 6, 0,  3,  3, 3, 0, 0, 1};
        tbl[7] = '{1, 6, 0,  7,  5, 7, 0, 1, 0};

        // Reset state
        #2;
        check("reset_state", int'({cars, aevt, devt, ovf, udf}), 0);
        tick(); tick();
        rst = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick();
            check("idle", int'({cars, aevt, devt, ovf, udf}), 0);
        end

        // First arrival: pulse and increment exactly 5 edges after first high sample
        arrive_det = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            if (k == 7) arrive_det = 1'b0;
            tick();
            if (k == 5) begin
                check("lat_pre_evt", int'(aevt), 0);
                check("lat_pre_cars", int'(cars), 0);
            end
            if (k == 6) begin
                check("lat_evt", int'(aevt), 1);
                check("lat_cars", int'(cars), 1);
            end
            if (k == 7) begin
                check("lat_evt_width", int'(aevt), 0);
                check("lat_cars_hold", int'(cars), 1);
            end
        end

        for (int r = 0; r < 8; r++) begin
            run_windows(tbl[r].sel, tbl[r].a_hi, tbl[r].d_hi, tbl[r].rep, ae, de);
            check($sformatf("row%0d_cars", r), int'(tbl[r].sel ? cars5 : cars), tbl[r].cars);
            check($sformatf("row%0d_aevt", r), ae, tbl[r].aevt);
            check($sformatf("row%0d_devt", r), de, tbl[r].devt);
            check($sformatf("row%0d_ovf", r), int'(tbl[r].sel ? ovf5 : ovf), int'(tbl[r].ovf));
            check($sformatf("row%0d_udf", r), int'(tbl[r].sel ? udf5 : udf), int'(tbl[r].udf));
        end

        // Clear on the saturated instance, then one more arrival counts from 0
        clr5 = 1'b1;
        tick();
        clr5 = 1'b0;
        check("clr_cars", int'(cars5), 0);
        check("clr_ovf", int'(ovf5), 0);
        run_windows(1'b1, 6, 0, 1, ae, de);
        check("post_clr_cars", int'(cars5), 1);
        check("post_clr_ovf", int'(ovf5), 0);

        // Asynchronous reset while an arrival is mid-debounce
        check("pre_rst_cars", int'(cars), 3);
        arrive_det = 1'b1;
        tick(); tick(); tick();
        rst = 1'b0;
        #2;
        check("async_rst_cars", int'(cars), 0);
        check("async_rst_udf", int'(udf), 0);
        tick();
        rst = 1'b1;
        ae = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            ae += int'(aevt);
        end
        check("rel_high_evts", ae, 1);
        check("rel_high_cars", int'(cars), 1);
        arrive_det = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mr_car_counter.md
Name: mr_car_counter

Overview:
- Upstream feeder for the smart traffic light controller.
- Converts raw main-road loop-detector pulses into the 8-bit waiting-car count that drives the controller's MR_cars input.
- Two detectors: arrival (upstream of the stop line) and departure (at the stop line). Count = arrivals minus departures, saturating.
- Each detector input is synchronised and debounced before it is counted.

Parameters:
- WIDTH, 8: width of the MR_cars count.
- DEBOUNCE, 3: consecutive synchronised cycles a detector level must hold to be accepted. Legal range is 1 to 15.
- MAX_CARS, 255: saturation ceiling for MR_cars. Must be ≤ 2^WIDTH-1.

Ports:
- clk  input  1  system clock; 1 GHz in the system bench.
- rst  input  1  asynchronous, active-low reset.
- arrive_det  input  1  raw arrival loop detector; asynchronous level, 1 = vehicle over loop.
- depart_det  input  1  raw departure loop detector; same semantics as arrive_det.
- clr  input  1  synchronous clear of count and flags.
- MR_cars  output  WIDTH  registered waiting-car count; connects to the controller's MR_cars.
- arrive_evt  output  1  one-cycle pulse per accepted arrival.
- depart_evt  output  1  one-cycle pulse per accepted departure.
- ovf  output  1  sticky flag: an arrival occurred while the count was at MAX_CARS.
- udf  output  1  sticky flag: a departure occurred while the count was 0.

Behaviour:
- Reset (rst=0, asynchronous): MR_cars=0, arrive_evt=0, depart_evt=0, ovf=0, udf=0. Sync flops, debounced levels and debounce counters are also cleared to 0.
- Per-channel pipeline (arrival and departure are identical and independent):
  - Synchroniser: two flops, s1 then s2.
  - Debounce counter: cnt, 4 bits.
  - Debounced level: deb.
  - While s2==deb: cnt←0.
  - While s2!=deb: cnt increments each cycle. When cnt==DEBOUNCE-1 and s2 still differs, deb←s2 and cnt←0.
  - A mismatch lasting fewer than DEBOUNCE consecutive cycles is discarded; cnt returns to 0 on the first matching cycle.
  - Event: evt_next = deb rose this cycle (0→1). Falling edges generate no event.
- Latency: raw level first sampled at edge E0 → s2 valid at E1 → deb set at E(1+DEBOUNCE) → arrive_evt/depart_evt high and MR_cars updated at edge E(2+DEBOUNCE). Each evt pulse is exactly one cycle wide.
- Count update (registered, same edge as evt; outcomes in priority order):
  - clr=1: MR_cars←0, ovf←0, udf←0. Evt pulses still fire.
  - Arrival and departure in the same cycle: MR_cars unchanged, no flag change.
  - Arrival only: if MR_cars<MAX_CARS, increment; otherwise hold and set ovf.
  - Departure only: if MR_cars>0, decrement; otherwise hold and set udf.
  - Neither: hold.
- Width rules:
  - Count arithmetic uses exactly WIDTH bits; saturation guarantees no wrap-around.
  - ovf and udf stay set until clr or reset.
- Detector high at reset release: deb starts at 0, so a detector held high counts as one event after the normal latency. This is intentional: a vehicle over the loop is counted.
- Reset mid-debounce: the pending transition is lost, and the count returns to 0 immediately (asynchronous).
- Maximum accepted event rate per channel is one per 2×DEBOUNCE cycles, since a full high-then-low cycle is needed. Faster toggling is filtered, not miscounted.

Test Plan (DEBOUNCE=3, MAX_CARS=255 unless stated):
- Reset release with detectors low; no stimulus for 20 cycles → MR_cars=0, both evt=0, ovf=udf=0 throughout.
- arrive_det high for 6 cycles, then low for 6, repeated 10 times → 10 arrive_evt pulses, MR_cars=10. Each increment lands exactly 5 edges after the rising sample.
- arrive_det glitch high for 2 cycles, 12 times → no arrive_evt, MR_cars unchanged.
- Departures:
  - From 10 cars, 4 clean depart_det pulses → MR_cars=6.
  - Then arrival and departure pulses aligned to the same edge → MR_cars stays 6.
  - Then 7 departures → MR_cars=0 and udf=1.
- Overflow, MAX_CARS=5: 7 arrivals → MR_cars=5 and ovf=1. Then clr=1 for one cycle → MR_cars=0 and ovf=0.
- rst driven low mid-count (MR_cars=3) during an in-flight debounce → MR_cars=0 immediately. After release with arrive_det held high, exactly one arrival is counted.
